// File: rtl/sumdsp_if.sv
`default_nettype none
// ============================================================================
// Module   : sumdsp_if
// Brief    : Operand/result handshake bundle for the segmented DSP adder.
// Revision : 1.0
// ============================================================================
interface sumdsp_if #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int Y_WIDTH = 33
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [A_WIDTH-1:0] a_i;
  logic [B_WIDTH-1:0] b_i;
  logic               cin_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [Y_WIDTH-1:0] y_o;
  logic               carry_o;

  modport master (
    output in_valid_i, a_i, b_i, cin_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, carry_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, carry_o
  );
endinterface
`default_nettype wire

// File: rtl/sumdsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sumdsp_pipe
// Brief    : Pipelined segmented-carry adder, one SEG_WIDTH slice per stage.
// Revision : 1.0
// ============================================================================
module sumdsp_pipe #(
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int A_WIDTH   = 32,
  parameter int B_WIDTH   = 32,
  parameter int Y_WIDTH   = 33,
  parameter int SEG_WIDTH = 12
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  sumdsp_if.slave   bus
);

  localparam int   NSEG     = (Y_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam logic c_SIGNED = (A_SIGNED == 1) && (B_SIGNED == 1);

  logic [Y_WIDTH-1:0] w_a_ext;
  logic [Y_WIDTH-1:0] w_b_ext;
  logic               w_en;

  // Bit-wise extension: truncates wide operands, pads narrow ones.
  for (genvar i = 0; i < Y_WIDTH; i++) begin : g_ext
    if (i < A_WIDTH) begin : g_a_in
      assign w_a_ext[i] = bus.a_i[i];
    end else begin : g_a_pad
      assign w_a_ext[i] = c_SIGNED & bus.a_i[A_WIDTH-1];
    end
    if (i < B_WIDTH) begin : g_b_in
      assign w_b_ext[i] = bus.b_i[i];
    end else begin : g_b_pad
      assign w_b_ext[i] = c_SIGNED & bus.b_i[B_WIDTH-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int c_LO  = k * SEG_WIDTH;
    localparam int c_REM = Y_WIDTH - c_LO;
    localparam int c_W   = (c_REM < SEG_WIDTH) ? c_REM : SEG_WIDTH;

    // Operands carry only the not-yet-added upper bits, LSB-aligned.
    logic [c_REM-1:0]    w_a;
    logic [c_REM-1:0]    w_b;
    logic                w_ci;
    logic                w_vi;
    logic [c_W:0]        w_sum;
    logic                r_vld;
    logic                r_c;
    logic [c_LO+c_W-1:0] r_y;

    assign w_sum = {1'b0, w_a[c_W-1:0]} + {1'b0, w_b[c_W-1:0]} + {{c_W{1'b0}}, w_ci};

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
      end else if (w_en) begin
        r_vld <= w_vi;
        if (w_vi) begin
          r_c <= w_sum[c_W];
        end
      end
    end

    if (k == 0) begin : g_head
      assign w_a  = w_a_ext;
      assign w_b  = w_b_ext;
      assign w_ci = bus.cin_i;
      assign w_vi = bus.in_valid_i;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_y <= '0;
        end else if (w_en && w_vi) begin
          r_y <= w_sum[c_W-1:0];
        end
      end
    end else begin : g_body
      assign w_a  = g_stage[k-1].g_fwd.r_a;
      assign w_b  = g_stage[k-1].g_fwd.r_b;
      assign w_ci = g_stage[k-1].r_c;
      assign w_vi = g_stage[k-1].r_vld;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_y <= '0;
        end else if (w_en && w_vi) begin
          r_y <= {w_sum[c_W-1:0], g_stage[k-1].r_y};
        end
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [c_REM-c_W-1:0] r_a;
      logic [c_REM-c_W-1:0] r_b;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en && w_vi) begin
          r_a <= w_a[c_REM-1:c_W];
          r_b <= w_b[c_REM-1:c_W];
        end
      end
    end
  end

  // Whole pipeline moves in lockstep; bubbles are kept, not squeezed.
  assign w_en            = !g_stage[NSEG-1].r_vld || bus.out_ready_i;
  assign bus.in_ready_o  = w_en;
  assign bus.out_valid_o = g_stage[NSEG-1].r_vld;
  assign bus.y_o         = g_stage[NSEG-1].r_y;
  assign bus.carry_o     = g_stage[NSEG-1].r_c;

endmodule
`default_nettype wire

// File: tb/tb_sumdsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sumdsp_pipe
// Brief    : Bench for sumdsp_pipe across all four signedness combinations.
// Revision : 1.0
// ============================================================================
module tb_sumdsp_pipe;

  localparam int AW = 32;
  localparam int BW = 32;
  localparam int YW = 33;
  localparam int SW = 12;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          cin       = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] a         = '0;
  logic [BW-1:0] b         = '0;

  logic [3:0]    ov;
  logic [3:0]    ir;
  logic [3:0]    cy;
  logic [YW-1:0] yv [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [YW-1:0] y;
    logic          c;
  } res_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          cin;
    int            inst;
    logic [YW-1:0] y;
    logic          c;
  } vec_t;

  res_t q [4][$];

  always #5 clk = ~clk;

  // Instance index i: A_SIGNED = i/2, B_SIGNED = i%2.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sumdsp_if #(.A_WIDTH(AW), .B_WIDTH(BW), .Y_WIDTH(YW)) u_if ();

    assign u_if.in_valid_i  = in_valid;
    assign u_if.a_i         = a;
    assign u_if.b_i         = b;
    assign u_if.cin_i       = cin;
    assign u_if.out_ready_i = out_ready;
    assign ov[gi]           = u_if.out_valid_o;
    assign ir[gi]           = u_if.in_ready_o;
    assign cy[gi]           = u_if.carry_o;
    assign yv[gi]           = u_if.y_o;

    sumdsp_pipe #(
      .A_SIGNED (gi / 2),
      .B_SIGNED (gi % 2),
      .A_WIDTH  (AW),
      .B_WIDTH  (BW),
      .Y_WIDTH  (YW),
      .SEG_WIDTH(SW)
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (u_if)
    );
  end

  // Reference: extend to 64 bits, add, take low YW bits and bit YW as carry.
  function automatic res_t model(int inst, logic [AW-1:0] ma, logic [BW-1:0] mb, logic mc);
    logic [63:0] ae, be, s;
    logic [63:0] mask;
    res_t r;
    mask = (64'd1 << YW) - 64'd1;
    ae = {32'd0, ma};
    be = {32'd0, mb};
    if (inst == 3) begin
      if (ma[AW-1]) ae = ae | ~((64'd1 << AW) - 64'd1);
      if (mb[BW-1]) be = be | ~((64'd1 << BW) - 64'd1);
    end
    ae = ae & mask;
    be = be & mask;
    s = ae + be + {63'd0, mc};
    r.y = s[YW-1:0];
    r.c = s[YW];
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on out_valid&&out_ready, push on in_valid&&in_ready.
  task automatic sb_step();
    res_t e;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i] === 1'b1 && out_ready) begin
          if (q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected inst=%0d actual=0x%0h expected=none", i, yv[i]);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("sb_y%0d", i), 64'(yv[i]), 64'(e.y));
            chk($sformatf("sb_c%0d", i), 64'(cy[i]), 64'(e.c));
          end
        end
        if (in_valid && ir[i] === 1'b1) q[i].push_back(model(i, a, b, cin));
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    sb_step();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t          vt [8];
  logic [AW-1:0] pa [5];
  logic [BW-1:0] pb [5];
  logic          pc [5];
  res_t          pe [5];
  int            acc;

  initial begin
    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 33'h1_0000_0000, 1'b0};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 33'h1_FFFF_FFFE, 1'b1};
    vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 33'h1_FFFF_FFFE, 1'b0};
    vt[3] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 0, 33'h0_0100_0000, 1'b0};
    vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 33'h1_FFFF_FFFF, 1'b0};
    vt[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 3, 33'h1_0000_0000, 1'b1};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1, 33'h0_0000_0001, 1'b0};
    vt[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3, 33'h0_0000_0000, 1'b1};

    rst_n = 1'b0;
    pos();
    pos();
    rst_n = 1'b1;
    neg();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", 64'(ov[i]), 64'd0);
      chk("rst_y",     64'(yv[i]), 64'd0);
      chk("rst_carry", 64'(cy[i]), 64'd0);
      chk("rst_ready", 64'(ir[i]), 64'd1);
    end
    pos();

    // Directed vectors with latency probe: valid must rise exactly 2 edges after accept.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      a = vt[v].a;
      b = vt[v].b;
      cin = vt[v].cin;
      neg();
      pos();
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      cin = 1'b0;
      neg();
      chk("lat_e1", 64'(ov[vt[v].inst]), 64'd0);
      pos();
      neg();
      chk("lat_e2", 64'(ov[vt[v].inst]), 64'd0);
      pos();
      neg();
      chk($sformatf("vec%0d_valid", v), 64'(ov[vt[v].inst]), 64'd1);
      chk($sformatf("vec%0d_y", v),     64'(yv[vt[v].inst]), 64'(vt[v].y));
      chk($sformatf("vec%0d_c", v),     64'(cy[vt[v].inst]), 64'(vt[v].c));
      pos();
    end

    // Backpressure: 5 pairs, consumer stalled until the pipeline is full.
    for (int i = 0; i < 5; i++) begin
      pa[i] = rnd_op();
      pb[i] = rnd_op();
      pc[i] = 1'($urandom_range(0, 1));
      pe[i] = model(0, pa[i], pb[i], pc[i]);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      a   = pa[(c < 3) ? c : 3];
      b   = pb[(c < 3) ? c : 3];
      cin = pc[(c < 3) ? c : 3];
      neg();
      if (c >= 3) begin
        chk("bp_ready", 64'(ir[0]), 64'd0);
        chk("bp_valid", 64'(ov[0]), 64'd1);
        chk("bp_hold",  64'(yv[0]), 64'(pe[0].y));
      end
      pos();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 2);
      if (c < 2) begin
        a = pa[3 + c];
        b = pb[3 + c];
        cin = pc[3 + c];
      end else begin
        a = $urandom;
        b = $urandom;
      end
      neg();
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      chk("bp_out_y",     64'(yv[0]), 64'(pe[c].y));
      chk("bp_out_c",     64'(cy[0]), 64'(pe[c].c));
      pos();
    end
    in_valid = 1'b0;
    neg();
    chk("bp_no_dup", 64'(ov[0]), 64'd0);
    pos();

    // Reset with two operations in flight.
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a = rnd_op();
      b = rnd_op();
      neg();
      pos();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    neg();
    pos();
    rst_n = 1'b1;
    neg();
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_valid", 64'(ov[i]), 64'd0);
      chk("mid_rst_y",     64'(yv[i]), 64'd0);
      chk("mid_rst_ready", 64'(ir[i]), 64'd1);
    end
    pos();
    for (int c = 0; c < 5; c++) begin
      neg();
      chk("mid_rst_stale", 64'(ov), 64'd0);
      pos();
    end

    // Random stream with random backpressure, all four instances scored.
    acc = 0;
    for (int c = 0; c < 6000 && acc < 1000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      a         = rnd_op();
      b         = rnd_op();
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      neg();
      if (in_valid && ir[0] === 1'b1) acc++;
      pos();
    end
    chk("rnd_accepted", 64'(acc), 64'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      neg();
      pos();
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_empty%0d", i), 64'(q[i].size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
